// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencer: FSM states, LFSR geometry and
// the lock-up guard values.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int LFSR_W = 8;
    localparam int TAP_HI = 7;
    localparam int TAP_LO = 3;

    localparam logic [LFSR_W-1:0] LOCKUP_VAL = 8'hFF;
    localparam logic [LFSR_W-1:0] SEED_SUBST = 8'h00;

    // XNOR feedback: all-ones is the lock-up state, all-zeros is a legal seed.
    function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ~(v[TAP_HI] ^ v[TAP_LO])};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// 8-bit XNOR-feedback LFSR register with parallel load; load beats step.
module lfsr_core
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] out
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lfsr <= '0;
        end else if (load) begin
            r_lfsr <= load_val;
        end else if (step) begin
            r_lfsr <= lfsrNext(r_lfsr);
        end
    end

    assign out = r_lfsr;

endmodule

// File: rtl/lfsr_sequencer.sv
// Seeds and advances an LFSR, then streams a requested number of random bytes
// over valid/ready, finishing with a one-cycle done pulse.
module lfsr_sequencer
    import lfsr_pkg::*;
#(
    parameter int STEPS_PER_WORD = 8,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [LFSR_W-1:0] seed,
    input  logic [CNT_W-1:0]  num_words,
    output logic [LFSR_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] STEP_RELOAD = 8'(STEPS_PER_WORD - 1);

    state_t            r_state;
    state_t            w_stateNext;
    logic [CNT_W-1:0]  r_remaining;
    logic [7:0]        r_stepCnt;
    logic              w_accept;
    logic              w_handshake;
    logic              w_step;
    logic [LFSR_W-1:0] w_loadVal;

    assign w_accept    = (r_state == IDLE) && start && !abort;
    assign w_handshake = (r_state == PRESENT) && rnd_ready && !abort;
    assign w_step      = (r_state == STEP) && !abort;
    assign w_loadVal   = (seed == LOCKUP_VAL) ? SEED_SUBST : seed;

    lfsr_core u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (w_accept),
        .load_val (w_loadVal),
        .step     (w_step),
        .out      (rnd_data)
    );

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stateNext = (num_words == '0) ? DONE : STEP;
                end
            end
            STEP: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else if (r_stepCnt == '0) begin
                    w_stateNext = PRESENT;
                end
            end
            PRESENT: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else if (rnd_ready) begin
                    w_stateNext = (r_remaining == CNT_W'(1)) ? DONE : STEP;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // remaining is at least 1 whenever PRESENT is reached, so it cannot wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_stepCnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_remaining <= num_words;
                r_stepCnt   <= STEP_RELOAD;
            end else if (w_step && (r_stepCnt != '0)) begin
                r_stepCnt <= r_stepCnt - 8'd1;
            end else if (w_handshake) begin
                r_remaining <= r_remaining - CNT_W'(1);
                r_stepCnt   <= STEP_RELOAD;
            end
        end
    end

    assign rnd_valid = (r_state == PRESENT);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Scoreboard bench for lfsr_sequencer: the driver queues expected words from a
// reference model, a negedge monitor pops and compares on every handshake.
module tb_lfsr_sequencer;

    localparam int STEPS = 8;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } expWord_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic [7:0]       seed;
    logic [CNT_W-1:0] numWords;
    logic [7:0]       rndData;
    logic             rndValid;
    logic             rndReady;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    expWord_t   expQ[$];
    logic       pendingDone = 1'b0;
    logic       zeroTxn = 1'b0;
    logic       heldValid = 1'b0;
    logic [7:0] heldData = 8'h00;

    lfsr_sequencer #(
        .STEPS_PER_WORD (STEPS),
        .CNT_W          (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .seed      (seed),
        .num_words (numWords),
        .rnd_data  (rndData),
        .rnd_valid (rndValid),
        .rnd_ready (rndReady),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: feedback bit is 1 when the two tap bits agree.
    function automatic logic [7:0] modelAdvance(input logic [7:0] v, input int k);
        int x;
        int fb;
        x = int'(v);
        for (int i = 0; i < k; i++) begin
            fb = (((x >> 7) & 1) == ((x >> 3) & 1)) ? 1 : 0;
            x  = ((x << 1) & 255) | fb;
        end
        return 8'(x);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        expWord_t e;
        if (pendingDone || (done && !zeroTxn)) begin
            checkOutput("done_pulse", 32'(done), 32'(pendingDone));
        end
        pendingDone = 1'b0;
        if (heldValid) begin
            checkOutput("hold_valid", 32'(rndValid), 32'd1);
            checkOutput("hold_data", 32'(rndData), 32'(heldData));
        end
        if (rndValid && rndReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_word", 32'(rndData), 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("word_data", 32'(rndData), 32'(e.data));
                if (e.last) pendingDone = 1'b1;
            end
        end
        heldValid = rndValid && !rndReady && !abort && reset;
        heldData  = rndData;
    end

    task automatic waitIdle();
        int k = 0;
        while (busy && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
    endtask

    // One command: queue the model's words, then drive ready/abort each cycle.
    task automatic applyStimulus(input logic [7:0] s, input int n, input int readyPct,
                                 input int hold, input int abortAt,
                                 input bit startWithAbort, input int expFirst);
        logic [7:0] base;
        int c = 0;
        int fv = -1;
        bit aborted = 0;
        waitIdle();
        base = (s == 8'hFF) ? 8'h00 : s;
        for (int i = 0; i < n; i++) begin
            expQ.push_back('{data: modelAdvance(base, STEPS * (i + 1)), last: (i == n - 1)});
        end
        zeroTxn  = (n == 0);
        start    = 1'b1;
        seed     = s;
        numWords = CNT_W'(n);
        @(posedge clk); #1;
        while (1) begin
            start = 1'b0;
            if (n == 0 && c == 0) begin
                checkOutput("zero_done", 32'(done), 32'd1);
                checkOutput("zero_busy", 32'(busy), 32'd1);
                checkOutput("zero_valid", 32'(rndValid), 32'd0);
            end
            if (n > 0 && !aborted && c == STEPS - 1)
                checkOutput("latency_early", 32'(rndValid), 32'd0);
            if (n > 0 && !aborted && c == STEPS) begin
                checkOutput("latency_valid", 32'(rndValid), 32'd1);
                if (expFirst >= 0) checkOutput("first_word", 32'(rndData), 32'(expFirst));
            end
            if (n == 0 && c == 1) checkOutput("zero_valid_after", 32'(rndValid), 32'd0);
            if (!busy) break;
            if (c > 2000) begin
                checkOutput("txn_timeout", 32'(busy), 32'd0);
                break;
            end
            if (rndValid && fv < 0) fv = c;
            if (abortAt == c && expQ.size() > 0) begin
                abort    = 1'b1;
                rndReady = 1'b0;
                aborted  = 1;
                expQ.delete();
                if (startWithAbort) begin
                    start    = 1'b1;
                    seed     = 8'h00;
                    numWords = CNT_W'(1);
                end
            end else begin
                abort    = 1'b0;
                rndReady = (fv >= 0 && c < fv + hold) ? 1'b0 : ($urandom_range(99) < readyPct);
            end
            @(posedge clk); #1;
            c++;
        end
        abort    = 1'b0;
        start    = 1'b0;
        rndReady = 1'b0;
        if (aborted) begin
            checkOutput("abort_valid", 32'(rndValid), 32'd0);
            checkOutput("abort_done", 32'(done), 32'd0);
            @(posedge clk); #1;
            checkOutput("abort_start_ignored", 32'(busy), 32'd0);
        end
        zeroTxn = 1'b0;
    endtask

    initial begin
        int n;
        int ab;
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        seed     = 8'h00;
        numWords = '0;
        rndReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(rndValid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_data", 32'(rndData), 32'h00);
        reset = 1'b1;
        @(posedge clk); #1;

        applyStimulus(8'h00, 2, 100, 0, -1, 0, 8'hF0);
        applyStimulus(8'h00, 1, 100, 5, -1, 0, 8'hF0);
        applyStimulus(8'hFF, 1, 100, 0, -1, 0, 8'hF0);
        applyStimulus(8'h5A, 0, 100, 0, -1, 0, -1);

        // Reset while a word is presented and unaccepted.
        waitIdle();
        start    = 1'b1;
        seed     = 8'h00;
        numWords = CNT_W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (STEPS) @(posedge clk);
        #1;
        checkOutput("pre_reset_valid", 32'(rndValid), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checkOutput("midreset_valid", 32'(rndValid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_data", 32'(rndData), 32'h00);

        // Abort in STEP with a simultaneous start, then start+abort in IDLE.
        applyStimulus(8'h00, 2, 100, 0, 3, 1, -1);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("idle_start_abort", 32'(busy), 32'd0);
        applyStimulus(8'h00, 1, 100, 0, -1, 0, 8'hF0);

        for (int t = 0; t < 40; t++) begin
            n  = $urandom_range(5);
            ab = ($urandom_range(99) < 25) ? $urandom_range(n * 14) : -1;
            applyStimulus(8'($urandom), n, $urandom_range(30, 100), $urandom_range(3), ab, 0, -1);
        end

        waitIdle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_sequencer.md
Name: lfsr_sequencer

Overview:
- Controller that owns and sequences one 8-bit XNOR-feedback LFSR (taps bits 7 and 3, shift-left, feedback into bit 0).
- Seeds the LFSR on a start command and advances it STEPS_PER_WORD times per output word.
- Delivers a requested number of pseudo-random bytes over a valid/ready stream, then pulses done.
- Sits between a command source (e.g. test/BIST control) and any consumer of random bytes.

Parameters:
STEPS_PER_WORD, 8, LFSR shifts between consecutive output words; legal range 1..255.
CNT_W, 8, width of the word-count input and the internal remaining-words counter.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-low reset.
start  input  1  command strobe; sampled only in IDLE.
abort  input  1  cancels the sequence in progress; sampled in every state.
seed  input  8  LFSR seed; captured when start is accepted.
num_words  input  CNT_W  words to deliver; captured when start is accepted.
rnd_data  output  8  current LFSR register value; meaningful only while rnd_valid=1.
rnd_valid  output  1  word available.
rnd_ready  input  1  consumer accepts the word when rnd_valid&rnd_ready.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when the last word is accepted.

Behaviour:
- Reset (reset=0 at posedge), including mid-sequence: state=IDLE, lfsr=8'h00, rnd_valid=0, busy=0, done=0, counters=0.
- LFSR step: lfsr <= {lfsr[6:0], ~(lfsr[7]^lfsr[3])}. Lock-up value is 8'hFF.
- IDLE: on start=1 and abort=0:
  - lfsr <= seed, except seed==8'hFF, which loads 8'h00.
  - remaining <= num_words; step_cnt <= STEPS_PER_WORD-1.
  - If num_words==0, go to DONE; otherwise go to STEP.
- STEP: shift the LFSR every cycle. When step_cnt==0, the shift still happens and state goes to PRESENT; otherwise step_cnt decrements.
- Latency: rnd_valid rises exactly STEPS_PER_WORD cycles after the edge that accepted start.
- PRESENT: rnd_valid=1, and the LFSR holds.
  - rnd_data is stable while rnd_valid=1 and rnd_ready=0.
  - On rnd_valid&rnd_ready: remaining decrements. If remaining==1, go to DONE; otherwise go to STEP with step_cnt <= STEPS_PER_WORD-1.
  - rnd_valid drops the cycle after acceptance.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. done is registered.
- abort=1 in STEP, PRESENT or DONE: next state IDLE, rnd_valid=0, no done pulse. The LFSR keeps its value.
  - abort wins over a simultaneous handshake in PRESENT; that word counts as not delivered.
- start while busy: ignored.
- start and abort together in IDLE: abort wins; stay IDLE.
- A new start in the cycle after returning to IDLE is accepted.
- remaining is unsigned CNT_W bits and never wraps, because it is checked before decrementing.
- Outputs rnd_valid, busy and done are decoded from registered state only; no combinational path from any input.

Decomposition:
- Shared package lfsr_pkg:
  - state encoding: IDLE, STEP, PRESENT, DONE (2-bit).
  - LFSR_W = 8, TAP_HI = 7, TAP_LO = 3.
  - LOCKUP_VAL = 8'hFF, SEED_SUBST = 8'h00.
- Sub-module lfsr_core:
  - Ports clk, reset (same sync active-low reset), load, load_val[7:0], step, out[7:0].
  - load has priority over step.
- The sequencer holds only the FSM and the counters.

Test Plan:
- Reset mid-PRESENT (rnd_valid=1): reset=0 for 1 cycle -> next cycle rnd_valid=0, busy=0, done=0, rnd_data=8'h00, state IDLE.
- seed=8'h00, num_words=2, STEPS_PER_WORD=8, rnd_ready=1:
  - first valid 8 cycles after start, rnd_data=8'hF0;
  - second word rnd_data=8'h0F;
  - done pulses 1 cycle after the second handshake, then busy=0.
- Backpressure: seed=8'h00, num_words=1, rnd_ready=0 for 5 cycles -> rnd_valid and rnd_data=8'hF0 held stable; accepted on the cycle ready=1; done follows.
- Lock-up guard: seed=8'hFF, num_words=1 -> first word 8'hF0 (identical to seed 8'h00).
- num_words=0 -> busy for 1 cycle, done pulse, rnd_valid never asserts.
- Abort in STEP, then start with seed=8'h00 asserted while busy and abort -> return to IDLE, no done, start ignored; a subsequent clean start gives first word 8'hF0.
